// File: rtl/dbg_pkg.sv
// Shared definitions for the debug-bus scan sequencer.
//   ds_state_e     : sequencer state encoding (DS_IDLE..DS_DONE)
//   REG_*          : region select values carried in chk_addr[19:16]
//   READ_LAT_DEF   : default debug-bus read latency in cycles (1..7)
//   CNT_W_DEF      : default width of the burst word count
//   next_scan_addr : burst address step that never leaves the current region
package dbg_pkg;

  typedef enum logic [2:0] {
    DS_IDLE  = 3'd0,
    DS_ISSUE = 3'd1,
    DS_WAIT  = 3'd2,
    DS_SEND  = 3'd3,
    DS_DONE  = 3'd4
  } ds_state_e;

  localparam logic [3:0] REG_PROBE = 4'h0;
  localparam logic [3:0] REG_RF    = 4'h1;
  localparam logic [3:0] REG_IMU   = 4'h2;
  localparam logic [3:0] REG_DMU   = 4'h3;

  localparam int READ_LAT_DEF = 1;
  localparam int CNT_W_DEF    = 16;

  // Only the low half counts; the upper half is the region select and stays
  // fixed, so a long burst wraps inside its region instead of spilling over.
  function automatic logic [31:0] next_scan_addr(input logic [31:0] addr);
    return {addr[31:16], addr[15:0] + 16'd1};
  endfunction

endpackage

// File: rtl/debug_scan_ctrl.sv
// debug_scan_ctrl: single owner of the core's debug bus (chk_addr/chk_data).
// While idle the manual probe address passes straight through to chk_addr.
// On a command it walks cmd_count consecutive addresses from cmd_base, samples
// chk_data READ_LAT cycles after each address change and streams
// {out_addr, out_data} words over a valid/ready handshake.
//
// Ports
//   clk, rstn             clock, asynchronous active-low reset
//   man_addr              manual probe address, driven onto chk_addr in IDLE
//   cmd_valid/cmd_ready   burst request handshake (ready only in IDLE)
//   cmd_base, cmd_count   first address and number of words (0 = empty burst)
//   cmd_abort             cancel a running burst (ignored in IDLE)
//   chk_addr, chk_data    debug bus address out / read data in
//   out_valid/out_ready   stream handshake
//   out_addr, out_data    streamed word: address and sampled data
//   out_last              final word of the burst, qualified by out_valid
//   busy                  sequencer not in IDLE
//   done, aborted         one-cycle completion / cancellation pulses
module debug_scan_ctrl
  import dbg_pkg::*;
#(
  parameter int READ_LAT = READ_LAT_DEF,  // 1..7
  parameter int CNT_W    = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [31:0]      man_addr,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [31:0]      cmd_base,
  input  logic [CNT_W-1:0] cmd_count,
  input  logic             cmd_abort,
  output logic [31:0]      chk_addr,
  input  logic [31:0]      chk_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_addr,
  output logic [31:0]      out_data,
  output logic             out_last,
  output logic             busy,
  output logic             done,
  output logic             aborted
);

  // WAIT starts from READ_LAT-1 so that, counting the ISSUE cycle, the sample
  // lands READ_LAT+1 edges after chk_addr changed.
  localparam logic [2:0] LAT_LOAD = 3'(READ_LAT - 1);

  ds_state_e        state_q, state_d;
  logic [31:0]      cur_addr_q, cur_addr_d;
  logic [CNT_W-1:0] remain_q, remain_d;
  logic [2:0]       lat_cnt_q, lat_cnt_d;
  logic [31:0]      out_addr_q, out_addr_d;
  logic [31:0]      out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;
  logic             out_last_q, out_last_d;
  logic             done_q, done_d;
  logic             aborted_q, aborted_d;

  logic abort_req;
  logic last_word;
  logic lat_zero;

  assign abort_req = cmd_abort && (state_q != DS_IDLE);
  assign last_word = (remain_q == CNT_W'(1));
  assign lat_zero  = (lat_cnt_q == 3'd0);

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= DS_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  // NOTE: every combinational output gets a default before the case so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    if (abort_req) begin
      // Abort outranks a same-cycle stream handshake: that word is lost.
      state_d = DS_IDLE;
    end else begin
      unique case (state_q)
        DS_IDLE: begin
          if (cmd_valid) begin
            state_d = (cmd_count == '0) ? DS_DONE : DS_ISSUE;
          end
        end
        DS_ISSUE: state_d = DS_WAIT;
        DS_WAIT: begin
          if (lat_zero) state_d = DS_SEND;
        end
        DS_SEND: begin
          if (out_ready) state_d = last_word ? DS_DONE : DS_ISSUE;
        end
        DS_DONE: state_d = DS_IDLE;
        default: state_d = DS_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs decoded from the registered state
  // ---------------------------------------------------------------------------
  always_comb begin
    cmd_ready = (state_q == DS_IDLE);
    busy      = (state_q != DS_IDLE);
    // In a burst chk_addr comes from cur_addr_q, so it is glitch-free and
    // stable from ISSUE through SEND.
    chk_addr  = (state_q == DS_IDLE) ? man_addr : cur_addr_q;
  end

  // ---------------------------------------------------------------------------
  // Datapath: address walk, word count, latency counter, output word
  // ---------------------------------------------------------------------------
  always_comb begin
    cur_addr_d  = cur_addr_q;
    remain_d    = remain_q;
    lat_cnt_d   = lat_cnt_q;
    out_addr_d  = out_addr_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    done_d      = 1'b0;
    aborted_d   = 1'b0;

    if (abort_req) begin
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
      aborted_d   = 1'b1;
    end else begin
      unique case (state_q)
        DS_IDLE: begin
          if (cmd_valid) begin
            cur_addr_d = cmd_base;
            remain_d   = cmd_count;
          end
        end
        DS_ISSUE: lat_cnt_d = LAT_LOAD;
        DS_WAIT: begin
          if (lat_zero) begin
            out_addr_d  = cur_addr_q;
            out_data_d  = chk_data;
            out_valid_d = 1'b1;
            out_last_d  = last_word;
          end else begin
            lat_cnt_d = lat_cnt_q - 3'd1;
          end
        end
        DS_SEND: begin
          // out_* are simply held while the sink stalls.
          if (out_ready) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            if (!last_word) begin
              remain_d   = remain_q - CNT_W'(1);
              cur_addr_d = next_scan_addr(cur_addr_q);
            end
          end
        end
        DS_DONE: done_d = 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cur_addr_q  <= '0;
      remain_q    <= '0;
      lat_cnt_q   <= '0;
      out_addr_q  <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      done_q      <= 1'b0;
      aborted_q   <= 1'b0;
    end else begin
      cur_addr_q  <= cur_addr_d;
      remain_q    <= remain_d;
      lat_cnt_q   <= lat_cnt_d;
      out_addr_q  <= out_addr_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      done_q      <= done_d;
      aborted_q   <= aborted_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_addr  = out_addr_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  // Both pulses are registered, so they appear in the IDLE cycle that follows
  // DONE or the abort; an abort while in DONE therefore suppresses done.
  assign done      = done_q;
  assign aborted   = aborted_q;

endmodule

// File: tb/tb_debug_scan_ctrl.sv
// Bench for debug_scan_ctrl: a READ_LAT=1 instance (dut) and a READ_LAT=3
// instance (dut3) in front of pipelined debug-bus memory models. Expected
// stream words are queued when a burst is issued and popped on handshakes.
module tb_debug_scan_ctrl;
  import dbg_pkg::*;

  localparam int CW = 16;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic        last;
  } word_t;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---- dut (READ_LAT = 1) ----
  logic [31:0]   man_addr = '0;
  logic          cmd_valid = 1'b0, cmd_abort = 1'b0;
  logic [31:0]   cmd_base = '0;
  logic [CW-1:0] cmd_count = '0;
  logic [31:0]   chk_data = '0;
  logic          out_ready = 1'b1;
  logic          cmd_ready, out_valid, out_last, busy, done, aborted;
  logic [31:0]   chk_addr, out_addr, out_data;

  // ---- dut3 (READ_LAT = 3) ----
  logic [31:0]   man_addr3 = '0;
  logic          cmd_valid3 = 1'b0, cmd_abort3 = 1'b0, out_ready3 = 1'b1;
  logic [31:0]   cmd_base3 = '0;
  logic [CW-1:0] cmd_count3 = '0;
  logic [31:0]   chk_data3 = '0, p1 = '0, p2 = '0;
  logic          cmd_ready3, out_valid3, out_last3, busy3, done3, aborted3;
  logic [31:0]   chk_addr3, out_addr3, out_data3;

  debug_scan_ctrl #(.READ_LAT(1), .CNT_W(CW)) dut (
    .clk(clk), .rstn(rstn), .man_addr(man_addr),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_base(cmd_base),
    .cmd_count(cmd_count), .cmd_abort(cmd_abort),
    .chk_addr(chk_addr), .chk_data(chk_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr),
    .out_data(out_data), .out_last(out_last),
    .busy(busy), .done(done), .aborted(aborted)
  );

  debug_scan_ctrl #(.READ_LAT(3), .CNT_W(CW)) dut3 (
    .clk(clk), .rstn(rstn), .man_addr(man_addr3),
    .cmd_valid(cmd_valid3), .cmd_ready(cmd_ready3), .cmd_base(cmd_base3),
    .cmd_count(cmd_count3), .cmd_abort(cmd_abort3),
    .chk_addr(chk_addr3), .chk_data(chk_data3),
    .out_valid(out_valid3), .out_ready(out_ready3), .out_addr(out_addr3),
    .out_data(out_data3), .out_last(out_last3),
    .busy(busy3), .done(done3), .aborted(aborted3)
  );

  // Debug-bus contents: an arbitrary scramble of the address.
  function automatic logic [31:0] mem_f(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0F0F_1234;
  endfunction

  // Synchronous read pipelines: data for an address is valid READ_LAT edges
  // after the address is presented, and stale before that.
  always @(posedge clk) chk_data <= mem_f(chk_addr);
  always @(posedge clk) begin
    p1        <= mem_f(chk_addr3);
    p2        <= p1;
    chk_data3 <= p2;
  end

  // Sink ready: a level, or 1-of-3 backpressure.
  logic bp_mode = 1'b0, rdy_level = 1'b1;
  always @(posedge clk) begin
    #1;
    out_ready = bp_mode ? (cyc % 3 == 0) : rdy_level;
  end

  int n_checks = 0, n_fail = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  word_t sb_q[$], sb3_q[$];
  int done_cnt = 0, abort_cnt = 0, pop_cnt = 0, lost_cnt = 0, pop3_cnt = 0, done3_cnt = 0;

  // ---- monitor: dut ----
  logic  hold_pend = 1'b0, prev_valid = 1'b0;
  word_t hold_w;
  logic [31:0] prev_addr = '0;
  int addr_chg_cyc = 0;

  always @(negedge clk) begin
    if (!rstn) begin
      hold_pend  = 1'b0;
      prev_valid = 1'b0;
    end else begin
      if (chk_addr !== prev_addr) begin
        addr_chg_cyc = cyc;
        prev_addr    = chk_addr;
      end
      if (done) done_cnt++;
      if (aborted) abort_cnt++;
      if (out_valid && !prev_valid) check("lat1_word", 64'(cyc - addr_chg_cyc), 64'd2);
      prev_valid = out_valid;
      if (out_valid) begin
        if (hold_pend) begin
          check("hold_addr", out_addr, hold_w.addr);
          check("hold_data", out_data, hold_w.data);
          check("hold_last", out_last, hold_w.last);
        end
        if (out_ready) begin
          hold_pend = 1'b0;
          if (cmd_abort) lost_cnt++;
          else if (sb_q.size() == 0) check("sb_underflow", 1, 0);
          else begin
            word_t e;
            e = sb_q.pop_front();
            pop_cnt++;
            check("word_addr", out_addr, e.addr);
            check("word_data", out_data, e.data);
            check("word_last", out_last, e.last);
          end
        end else begin
          hold_pend = 1'b1;
          hold_w    = '{addr: out_addr, data: out_data, last: out_last};
        end
      end
    end
  end

  // ---- monitor: dut3 ----
  logic prev_valid3 = 1'b0;
  logic [31:0] prev_addr3 = '0;
  int addr_chg_cyc3 = 0;

  always @(negedge clk) begin
    if (!rstn) prev_valid3 = 1'b0;
    else begin
      if (chk_addr3 !== prev_addr3) begin
        addr_chg_cyc3 = cyc;
        prev_addr3    = chk_addr3;
      end
      if (done3) done3_cnt++;
      if (out_valid3 && !prev_valid3) check("lat3_word", 64'(cyc - addr_chg_cyc3), 64'd4);
      prev_valid3 = out_valid3;
      if (out_valid3 && out_ready3) begin
        if (sb3_q.size() == 0) check("sb3_underflow", 1, 0);
        else begin
          word_t e;
          e = sb3_q.pop_front();
          pop3_cnt++;
          check("w3_addr", out_addr3, e.addr);
          check("w3_data", out_data3, e.data);
          check("w3_last", out_last3, e.last);
        end
      end
    end
  end

  task automatic push_words(input logic [31:0] base, input int count, input bit to3);
    for (int i = 0; i < count; i++) begin
      word_t w;
      w.addr = {base[31:16], base[15:0] + 16'(i)};
      w.data = mem_f(w.addr);
      w.last = (i == count - 1);
      if (to3) sb3_q.push_back(w);
      else     sb_q.push_back(w);
    end
  endtask

  // Presents one command to dut while it is idle; acc = cycle of the accept edge.
  task automatic issue(input logic [31:0] base, input int count, input bit with_abort,
                       output int acc);
    @(posedge clk); #1;
    cmd_base  = base;
    cmd_count = CW'(count);
    cmd_valid = 1'b1;
    cmd_abort = with_abort;
    push_words(base, count, 1'b0);
    @(posedge clk); #1;
    acc       = cyc;
    cmd_valid = 1'b0;
    cmd_abort = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    bit ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      if (!busy && sb_q.size() == 0) ok = 1'b1;
    end
    if (!ok) check("timeout_idle", 0, 1);
  endtask

  initial begin
    int acc, d0, p0, a0;
    logic [31:0] base;

    // ---- reset state ----
    repeat (2) @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_addr", out_addr, 0);
    check("rst_out_data", out_data, 0);
    check("rst_flags", {out_last, busy, done, aborted}, 4'b0000);
    check("rst_cmd_ready", cmd_ready, 1);
    rstn = 1'b1;

    // ---- 1: manual probe pass-through ----
    @(posedge clk); #1;
    man_addr = 32'h0000_0001;
    #1;
    check("man_chk_addr", chk_addr, 32'h0000_0001);
    check("man_busy_ready", {busy, cmd_ready}, 2'b01);
    man_addr = 32'h0003_0ABC;
    #1;
    check("man_chk_addr2", chk_addr, 32'h0003_0ABC);
    man_addr = 32'h0000_0001;

    // ---- 2: RF x0..x3, no backpressure ----
    d0 = done_cnt; p0 = pop_cnt;
    base = {12'h000, REG_RF, 16'h0000};
    issue(base, 4, 1'b0, acc);
    @(negedge clk);
    check("b2_busy_ready", {busy, cmd_ready}, 2'b10);
    check("b2_chk_addr", chk_addr, 32'h0001_0000);
    wait_idle(100);
    repeat (2) @(negedge clk);
    check("b2_words", pop_cnt - p0, 4);
    check("b2_done_once", done_cnt - d0, 1);

    // ---- 3: region wrap under 1-of-3 backpressure ----
    d0 = done_cnt; p0 = pop_cnt;
    bp_mode = 1'b1;
    issue({12'h000, REG_DMU, 16'hFFFE}, 3, 1'b0, acc);
    wait_idle(200);
    bp_mode = 1'b0;
    repeat (2) @(negedge clk);
    check("b3_words", pop_cnt - p0, 3);
    check("b3_done_once", done_cnt - d0, 1);

    // ---- 4: empty burst, then back-to-back command queued during DONE ----
    d0 = done_cnt; p0 = pop_cnt;
    issue(32'h0001_0020, 0, 1'b0, acc);
    cmd_base  = 32'h0001_0008;
    cmd_count = CW'(1);
    cmd_valid = 1'b1;
    push_words(32'h0001_0008, 1, 1'b0);
    @(negedge clk);
    check("e4_in_done", {busy, cmd_ready, done, out_valid}, 4'b1000);
    @(negedge clk);
    check("e4_done_pulse", {done, busy, cmd_ready, out_valid}, 4'b1010);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(negedge clk);
    check("e4_b2b_busy", {busy, done}, 2'b10);
    wait_idle(50);
    repeat (2) @(negedge clk);
    check("e4_words", pop_cnt - p0, 1);
    check("e4_done_cnt", done_cnt - d0, 2);

    // ---- abort in IDLE ignored; cmd_valid with cmd_abort in IDLE accepted ----
    a0 = abort_cnt; d0 = done_cnt; p0 = pop_cnt;
    @(posedge clk); #1; cmd_abort = 1'b1;
    @(posedge clk); #1; cmd_abort = 1'b0;
    @(negedge clk);
    check("idle_abort", {aborted, busy}, 2'b00);
    issue(32'h0000_0100, 1, 1'b1, acc);
    wait_idle(50);
    repeat (2) @(negedge clk);
    check("va_words", pop_cnt - p0, 1);
    check("va_pulses", {32'(done_cnt - d0), 32'(abort_cnt - a0)}, {32'd1, 32'd0});

    // ---- 5a: abort in SEND with a same-cycle handshake ----
    a0 = abort_cnt; d0 = done_cnt; p0 = pop_cnt;
    rdy_level = 1'b0;
    issue(32'h0002_0010, 3, 1'b0, acc);
    begin
      bit seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
        @(negedge clk);
        if (out_valid) seen = 1'b1;
      end
      if (!seen) check("timeout_ab_valid", 0, 1);
    end
    rdy_level = 1'b1;
    @(posedge clk); #1; cmd_abort = 1'b1;
    @(posedge clk); #1; cmd_abort = 1'b0;
    @(negedge clk);
    check("ab_state", {aborted, done, busy, out_valid, cmd_ready}, 5'b10001);
    @(negedge clk);
    check("ab_pulse_1cyc", {aborted, done}, 2'b00);
    sb_q.delete();
    repeat (2) @(negedge clk);
    check("ab_lost", lost_cnt, 1);
    check("ab_counts", {32'(abort_cnt - a0), 32'(done_cnt - d0), 32'(pop_cnt - p0)},
          {32'd1, 32'd0, 32'd0});

    // ---- 5b: asynchronous reset in WAIT ----
    a0 = abort_cnt; d0 = done_cnt;
    issue(32'h0001_0004, 2, 1'b0, acc);
    @(posedge clk);
    #2 rstn = 1'b0;
    #1;
    check("rst_mid_valid", {out_valid, out_last, busy, done, aborted}, 5'b00000);
    check("rst_mid_word", {out_addr, out_data}, 64'd0);
    check("rst_mid_chk", {cmd_ready, chk_addr}, {1'b1, 32'h0000_0001});
    sb_q.delete();
    @(negedge clk);
    rstn = 1'b1;
    repeat (4) @(negedge clk);
    check("rst_no_pulse", {32'(abort_cnt - a0), 32'(done_cnt - d0)}, 64'd0);

    // ---- 6: READ_LAT = 3 instance ----
    p0 = pop3_cnt; d0 = done3_cnt;
    @(posedge clk); #1;
    cmd_base3  = {12'h000, REG_IMU, 16'h0040};
    cmd_count3 = CW'(2);
    cmd_valid3 = 1'b1;
    push_words({12'h000, REG_IMU, 16'h0040}, 2, 1'b1);
    @(posedge clk); #1;
    cmd_valid3 = 1'b0;
    begin
      bit ok = 1'b0;
      for (int i = 0; i < 100 && !ok; i++) begin
        @(negedge clk);
        if (!busy3 && sb3_q.size() == 0) ok = 1'b1;
      end
      if (!ok) check("timeout_idle3", 0, 1);
    end
    repeat (2) @(negedge clk);
    check("l3_words", pop3_cnt - p0, 2);
    check("l3_done", done3_cnt - d0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    n_checks++;
    n_fail++;
    $display("FAIL watchdog: simulation did not finish in time");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
